fball_sprite_ctrl: RTL and testbench
====================================

Name: fball_sprite_ctrl

Overview:
- Upstream controller for the 21x21 fireball sprite ROMs (ram_fball_up / ram_fball_down, 441 entries, 9-bit address).
- Launches a fireball from Mario's position on a fire request and runs per-frame motion: horizontal travel, gravity, ground bounce, despawn.
- Per pixel, computes the ROM read_address and the in-box flag from DrawX/DrawY. Also outputs the up/down animation frame select.
- The colour mapper consumes is_fball and fball_up. It muxes the two ROM colours and treats 24'h800080 as transparent.

Parameters:
- SIZE, 21, sprite edge length in pixels (address = row*SIZE + col, max 440).
- X_STEP, 4, horizontal pixels moved per frame.
- GRAVITY, 1, vy increment per frame.
- VY_MAX, 6, maximum downward speed (pixels/frame).
- BOUNCE_VY, 5, upward speed magnitude after a ground hit.
- MAX_BOUNCES, 3, ground hits before despawn.
- ANIM_FRAMES, 4, frames between fball_up toggles.
- SCREEN_W, 640, despawn when x >= SCREEN_W or x < 0.

Ports:
- Clk, input, 1, system clock (50 MHz).
- Reset_n, input, 1, asynchronous active-low reset.
- frame_clk, input, 1, vsync-rate tick, asynchronous to the frame; rising edge detected internally.
- fire, input, 1, level fire key; rising edge requests a launch.
- mario_x, input, 10, Mario left edge (pixels).
- mario_y, input, 10, Mario top edge (pixels).
- mario_left, input, 1, 1 = Mario faces left.
- ground_y, input, 10, y of the ground surface.
- DrawX, input, 10, current pixel column.
- DrawY, input, 10, current pixel row.
- read_address, output, 9, ROM address.
- is_fball, output, 1, current pixel lies inside an active fireball box.
- fball_up, output, 1, 1 = select up-frame ROM, 0 = down-frame ROM.
- active, output, 1, fireball in flight.

Behaviour:
- Reset (async, Reset_n=0): state IDLE; x=0, y=0 (signed 11-bit); vy=0; bounces=0; anim_cnt=0; dir_left=0. Outputs: read_address=0, is_fball=0, fball_up=1, active=0. Both edge-detect registers are cleared.
- frame_clk and fire each pass through a 2-flop synchroniser plus edge register. frame_tick and fire_pulse are each one Clk wide.
- FSM states: IDLE, FLY.
- IDLE, on fire_pulse:
  - Latch dir_left = mario_left.
  - x = mario_x + 16 if facing right, mario_x - SIZE if facing left.
  - y = mario_y + 8; vy = +2; bounces = 0; anim_cnt = 0; fball_up = 1.
  - Go to FLY. active = 1 from the next cycle.
- IDLE: fire_pulse while already in FLY is ignored (one fireball at a time).
- FLY, on each frame_tick, all updates are in one cycle, in this order:
  1. x += X_STEP, or x -= X_STEP if dir_left.
  2. ynext = y + vy. If ynext + SIZE >= ground_y: y = ground_y - SIZE, vy = -BOUNCE_VY, bounces += 1. Otherwise y = ynext, vy = min(vy + GRAVITY, VY_MAX).
  3. anim_cnt += 1. When anim_cnt reaches ANIM_FRAMES-1 it wraps to 0 and fball_up toggles.
  4. If the new x < 0, or new x >= SCREEN_W, or bounces reaches MAX_BOUNCES: go to IDLE, active = 0 on the next cycle.
- Simultaneous frame_tick and fire_pulse in FLY: fire is ignored.
- Simultaneous frame_tick and fire_pulse in IDLE: launch only, no motion that cycle.
- Pixel path (registered, latency 1 Clk):
  - dx = DrawX - x, dy = DrawY - y, both signed.
  - hit = active AND 0 <= dx < SIZE AND 0 <= dy < SIZE.
  - col = dir_left ? (SIZE-1-dx) : dx.
  - Next cycle: is_fball = hit; read_address = hit ? dy*SIZE + col : 0.
  - Multiply by the constant 21 using shift-add ((dy<<4)+(dy<<2)+dy). The result never exceeds 440.
- Reset mid-flight: returns to IDLE immediately, all outputs forced to reset values asynchronously.

Test Plan:
- Reset, then launch: assert Reset_n=0 while in FLY → active=0, is_fball=0, read_address=0, fball_up=1 with no clock edge. Release, mario_x=100, mario_y=300, mario_left=0, pulse fire → next cycle active=1, x=116, y=308, vy=2.
- Pixel addressing: x=116, y=308, facing right. DrawX=126, DrawY=318 → one cycle later is_fball=1, read_address=220. DrawX=137 → is_fball=0, read_address=0. Same pixel with dir_left=1: DrawX=126, DrawY=318 gives address 220 (centre). DrawX=116, DrawY=308 gives address 20.
- Gravity and bounce: ground_y=340, y=308, vy=2. Apply 4 frame_ticks → y=310, 313, 317, then clamp y=319, vy=-5, bounces=1. Next tick → y=314, vy=-4.
- Despawn on bounces: run until the third ground hit → active drops the cycle after that frame_tick. is_fball stays 0 for all DrawX/DrawY afterwards.
- Despawn on edge: dir_left=1, launch at mario_x=30 (x=9). First frame_tick → x=5; next → x=1; next → x<0, back to IDLE.
- Animation and fire lockout: during FLY, fball_up toggles every 4 frame_ticks (1,1,1,1,0,0,0,0,1…). A fire pulse mid-flight leaves x, y, vy unchanged. frame_tick and fire in the same cycle from IDLE → launch only, x = launch value.

Source files
------------

// File: rtl/fball_sprite_ctrl.sv
// Fireball sprite controller: launches from Mario, runs per-frame motion (travel,
// gravity, ground bounce, despawn) and produces the per-pixel ROM address/in-box flag.
module fball_sprite_ctrl #(
  parameter int X_STEP      = 4,
  parameter int GRAVITY     = 1,
  parameter int VY_MAX      = 6,
  parameter int BOUNCE_VY   = 5,
  parameter int MAX_BOUNCES = 3,
  parameter int ANIM_FRAMES = 4,
  parameter int SCREEN_W    = 640
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       fire,
  input  logic [9:0] mario_x,
  input  logic [9:0] mario_y,
  input  logic       mario_left,
  input  logic [9:0] ground_y,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic [8:0] read_address,
  output logic       is_fball,
  output logic       fball_up,
  output logic       active
);

  // Edge length is fixed by the 21x21 ROMs; the address multiply below is built for it.
  localparam int SIZE = 21;

  localparam logic signed [11:0] SIZE_W     = 12'(SIZE);
  localparam logic signed [11:0] STEP_W     = 12'(X_STEP);
  localparam logic signed [11:0] GRAV_W     = 12'(GRAVITY);
  localparam logic signed [11:0] VY_MAX_W   = 12'(VY_MAX);
  localparam logic signed [11:0] SCREEN_W_W = 12'(SCREEN_W);
  localparam logic signed [3:0]  VY_MAX_4   = 4'(VY_MAX);
  localparam logic signed [3:0]  BOUNCE_4   = 4'(-BOUNCE_VY);

  typedef enum logic {IDLE, FLY} state_t;

  state_t             state;
  logic [2:0]         frame_sync, fire_sync;
  logic               frame_tick, fire_pulse;
  logic signed [10:0] x, y;
  logic signed [3:0]  vy;
  logic [3:0]         bounces, anim_cnt;
  logic               dir_left;

  // Two synchroniser flops followed by the edge register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_sync <= '0;
      fire_sync  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      frame_sync <= {frame_sync[1:0], frame_clk};
      fire_sync  <= {fire_sync[1:0], fire};
    end
  end

  assign frame_tick = frame_sync[1] & ~frame_sync[2];
  assign fire_pulse = fire_sync[1] & ~fire_sync[2];

  logic signed [11:0] x_w, y_w, vy_w, ground_w;
  logic signed [11:0] x_new, y_sum, vy_inc;
  logic signed [10:0] y_floor, x_launch, y_launch;
  logic signed [3:0]  vy_fall;
  logic [3:0]         bounces_new;
  logic               landed, despawn;

  assign x_w      = {x[10], x};
  assign y_w      = {y[10], y};
  assign vy_w     = {{8{vy[3]}}, vy};
  assign ground_w = {2'b00, ground_y};

  assign x_new       = dir_left ? x_w - STEP_W : x_w + STEP_W;
  assign y_sum       = y_w + vy_w;
  assign landed      = (y_sum + SIZE_W) >= ground_w;
  assign y_floor     = $signed({1'b0, ground_y}) - 11'(SIZE);
  assign vy_inc      = vy_w + GRAV_W;
  assign vy_fall     = (vy_inc > VY_MAX_W) ? VY_MAX_4 : vy_inc[3:0];
  assign bounces_new = bounces + {3'b000, landed};
  assign despawn     = (x_new < 12'sd0) || (x_new >= SCREEN_W_W) ||
                       (bounces_new == 4'(MAX_BOUNCES));

  assign x_launch = mario_left ? $signed({1'b0, mario_x}) - 11'(SIZE)
                               : $signed({1'b0, mario_x}) + 11'sd16;
  assign y_launch = $signed({1'b0, mario_y}) + 11'sd8;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      x        <= '0;
      y        <= '0;
      vy       <= '0;
      bounces  <= '0;
      anim_cnt <= '0;
      dir_left <= 1'b0;
      fball_up <= 1'b1;
    end else begin
      case (state)
        IDLE: if (fire_pulse) begin
          dir_left <= mario_left;
          x        <= x_launch;
          y        <= y_launch;
          vy       <= 4'sd2;
          bounces  <= '0;
          anim_cnt <= '0;
          fball_up <= 1'b1;
          state    <= FLY;
        end
        FLY: if (frame_tick) begin
          x       <= x_new[10:0];
          y       <= landed ? y_floor : y_sum[10:0];
          vy      <= landed ? BOUNCE_4 : vy_fall;
          bounces <= bounces_new;
          if (anim_cnt == 4'(ANIM_FRAMES - 1)) begin
            anim_cnt <= '0;
            fball_up <= ~fball_up;
          end else begin
            anim_cnt <= anim_cnt + 4'd1;
          end
          if (despawn) state <= IDLE;
        end
      endcase
    end
  end

  assign active = (state == FLY);

  logic signed [11:0] dx, dy;
  logic [4:0]         col;
  logic [8:0]         address_next;
  logic               hit;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    dx           = {2'b00, DrawX} - x_w;
    dy           = {2'b00, DrawY} - y_w;
    hit          = 1'b0;
    col          = dx[4:0];
    address_next = '0;
    if (active && dx >= 0 && dx < SIZE_W && dy >= 0 && dy < SIZE_W) hit = 1'b1;
    if (dir_left) col = 5'(SIZE - 1) - dx[4:0];
    // row*21 as (row<<4)+(row<<2)+row
    address_next = ({4'b0000, dy[4:0]} << 4) + ({4'b0000, dy[4:0]} << 2) +
                   {4'b0000, dy[4:0]} + {4'b0000, col};
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      is_fball     <= 1'b0;
      read_address <= '0;
    end else begin
      is_fball     <= hit;
      read_address <= hit ? address_next : '0;
    end
  end

endmodule

// File: tb/tb_fball_sprite_ctrl.sv
// Bench for fball_sprite_ctrl: directed steps followed by randomized flights, all
// checked against a frame-level reference model of the fireball kept in the bench.
module tb_fball_sprite_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       frame_clk, fire, mario_left;
  logic [9:0] mario_x, mario_y, ground_y, draw_x, draw_y;
  logic [8:0] read_address;
  logic       is_fball, fball_up, active;

  int tests = 0;
  int fails = 0;

  // Reference model state (plain integers, one update per frame).
  int m_x, m_y, m_vy, m_b, m_cnt, m_up, m_act, m_left, m_ground;

  fball_sprite_ctrl dut (
    .Clk(clk), .Reset_n(reset_n), .frame_clk(frame_clk), .fire(fire),
    .mario_x(mario_x), .mario_y(mario_y), .mario_left(mario_left),
    .ground_y(ground_y), .DrawX(draw_x), .DrawY(draw_y),
    .read_address(read_address), .is_fball(is_fball), .fball_up(fball_up),
    .active(active)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input int exp);
    tests++;
    assert (obs === 16'(exp)) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_x = 0; m_y = 0; m_vy = 0; m_b = 0; m_cnt = 0; m_up = 1; m_act = 0; m_left = 0;
  endfunction

  function automatic void model_launch(input int mx, input int my, input int left);
    m_left = left;
    m_x    = left ? mx - 21 : mx + 16;
    m_y    = my + 8;
    m_vy   = 2; m_b = 0; m_cnt = 0; m_up = 1; m_act = 1;
  endfunction

  function automatic void model_frame();
    if (!m_act) return;
    m_x = m_left ? m_x - 4 : m_x + 4;
    if (m_y + m_vy + 21 >= m_ground) begin
      m_y = m_ground - 21; m_vy = -5; m_b++;
    end else begin
      m_y  = m_y + m_vy;
      m_vy = (m_vy + 1 > 6) ? 6 : m_vy + 1;
    end
    if (m_cnt == 3) begin m_cnt = 0; m_up = 1 - m_up; end
    else m_cnt++;
    if (m_x < 0 || m_x >= 640 || m_b >= 3) m_act = 0;
  endfunction

  // Expected ROM address for a pixel, or -1 when outside the live fireball.
  function automatic int pix_addr(input int px, input int py);
    int dx = px - m_x;
    int dy = py - m_y;
    if (!m_act || dx < 0 || dx >= 21 || dy < 0 || dy >= 21) return -1;
    return dy * 21 + (m_left ? 20 - dx : dx);
  endfunction

  task automatic tick();
    frame_clk = 1'b1; repeat (4) @(negedge clk);
    frame_clk = 1'b0; repeat (4) @(negedge clk);
    model_frame();
  endtask

  task automatic fire_press();
    fire = 1'b1; repeat (4) @(negedge clk);
    fire = 1'b0; repeat (4) @(negedge clk);
  endtask

  task automatic launch(input int mx, input int my, input int left, input bit with_tick);
    int n = 0;
    mario_x = 10'(mx); mario_y = 10'(my); mario_left = left[0];
    fire = 1'b1;
    if (with_tick) frame_clk = 1'b1;
    while (!active && n < 10) begin @(negedge clk); n++; end
    check("launch_active", active, 1);
    check("launch_latency", n, 3);
    repeat (2) @(negedge clk);
    fire = 1'b0; frame_clk = 1'b0;
    repeat (4) @(negedge clk);
    model_launch(mx, my, left);
  endtask

  task automatic probe(input string tag, input int px, input int py,
                       input int exp_hit, input int exp_addr);
    draw_x = 10'(px); draw_y = 10'(py);
    @(negedge clk);
    check({tag, "_hit"}, is_fball, exp_hit);
    check({tag, "_addr"}, read_address, exp_addr);
  endtask

  task automatic probe_model(input string tag, input int px, input int py);
    int a;
    if (px < 0) px = 0;
    if (px > 1023) px = 1023;
    if (py < 0) py = 0;
    if (py > 1023) py = 1023;
    a = pix_addr(px, py);
    probe(tag, px, py, (a >= 0) ? 1 : 0, (a >= 0) ? a : 0);
  endtask

  initial begin
    int gx[5] = '{120, 124, 128, 132, 136};
    int gy[5] = '{310, 313, 317, 319, 314};
    int gu[5] = '{1, 1, 1, 0, 0};
    int last_x, last_y;

    reset_n = 1'b0; frame_clk = 1'b0; fire = 1'b0; mario_left = 1'b0;
    mario_x = '0; mario_y = '0; ground_y = 10'd340; draw_x = '0; draw_y = '0;
    model_reset();
    m_ground = 340;
    repeat (3) @(negedge clk);
    check("rst_active", active, 0);
    check("rst_is_fball", is_fball, 0);
    check("rst_addr", read_address, 0);
    check("rst_up", fball_up, 1);
    reset_n = 1'b1;
    @(negedge clk);

    // Launch to the right and check the box edges.
    launch(100, 300, 0, 1'b0);
    check("launch_up", fball_up, 1);
    probe("px_origin", 116, 308, 1, 0);
    probe("px_centre", 126, 318, 1, 220);
    probe("px_right_edge", 136, 318, 1, 230);
    probe("px_past_right", 137, 318, 0, 0);
    probe("px_before_left", 115, 308, 0, 0);
    probe("px_below", 116, 329, 0, 0);

    // Gravity, first bounce and the climb after it.
    for (int i = 0; i < 5; i++) begin
      tick();
      probe("grav_pos", gx[i], gy[i], 1, 0);
      probe("grav_above", gx[i], gy[i] - 1, 0, 0);
      check("grav_up", fball_up, gu[i]);
    end

    // Keep flying until the third ground hit removes the fireball.
    for (int i = 0; i < 100 && m_act; i++) begin
      last_x = m_x; last_y = m_y;
      tick();
      check("bnc_active", active, m_act);
      check("bnc_up", fball_up, m_up);
      probe_model("bnc_pos", m_x, m_y);
    end
    check("bnc_count", m_b, 3);
    check("bnc_gone", active, 0);
    probe("bnc_old_box", last_x + 10, last_y + 10, 0, 0);
    probe("bnc_old_origin", last_x, last_y, 0, 0);

    // Facing left mirrors the column; fire while flying is ignored.
    launch(137, 300, 1, 1'b0);
    probe("lf_centre", 126, 318, 1, 220);
    probe("lf_origin", 116, 308, 1, 20);
    probe("lf_right_col", 136, 308, 1, 0);
    fire_press();
    check("lock_active", active, 1);
    probe("lock_origin", 116, 308, 1, 20);
    tick();
    probe("lock_moved", 112, 310, 1, 20);
    for (int i = 0; i < 3; i++) tick();
    check("lf_up_low", fball_up, m_up);

    // Reset mid-flight acts without a clock edge.
    draw_x = 10'(m_x + 3); draw_y = 10'(m_y + 3);
    @(posedge clk); #1;
    check("midrst_pre_hit", is_fball, 1);
    check("midrst_pre_up", fball_up, 0);
    reset_n = 1'b0;
    #1;
    check("midrst_active", active, 0);
    check("midrst_is_fball", is_fball, 0);
    check("midrst_addr", read_address, 0);
    check("midrst_up", fball_up, 1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    @(negedge clk);
    probe_model("midrst_after", 100, 300);

    // Leaving through the left edge.
    ground_y = 10'd400; m_ground = 400;
    launch(30, 100, 1, 1'b0);
    probe("edge_launch", 9, 108, 1, 20);
    tick();
    probe("edge_x5", 5, m_y, 1, 20);
    tick();
    probe("edge_x1", 1, m_y, 1, 20);
    tick();
    check("edge_gone", active, 0);
    probe("edge_after", 0, m_y, 0, 0);

    // Fire and frame tick together from IDLE: launch only.
    launch(200, 150, 0, 1'b1);
    probe("both_origin", 216, 158, 1, 0);
    probe("both_dx4", 220, 158, 1, 4);
    check("both_up", fball_up, 1);

    // Randomized flights.
    for (int f = 0; f < 12; f++) begin
      int g, mx, my, left, guard;
      guard = 0;
      while (m_act && guard < 200) begin tick(); guard++; end
      check("rnd_idle", active, m_act);
      g  = int'($urandom_range(200, 470));
      mx = int'($urandom_range(0, 600));
      my = int'($urandom_range(g - 120, g - 40));
      left = int'($urandom_range(0, 1));
      ground_y = 10'(g); m_ground = g;
      launch(mx, my, left, ($urandom_range(0, 2) == 0));
      probe_model("rnd_launch", m_x + int'($urandom_range(0, 20)), m_y + int'($urandom_range(0, 20)));
      for (int s = 0; s < 150 && m_act; s++) begin
        if ($urandom_range(0, 4) == 0) fire_press();
        else tick();
        check("rnd_active", active, m_act);
        check("rnd_up", fball_up, m_up);
        probe_model("rnd_px", m_x + int'($urandom_range(0, 24)) - 2,
                    m_y + int'($urandom_range(0, 24)) - 2);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
